i2c_write_sequencer: RTL and testbench
======================================

Name: i2c_write_sequencer

Overview:
Parametrised successor to the fixed three-byte I2C write controller. It sequences a complete I2C write: START, slave address, 0–2 register-address bytes, 1–MAX_DATA_BYTES data bytes, STOP and bus-free. It adds NACK detection with optional abort, a busy flag and a captured error index. It sits between the register/command layer and the byte shifter (the shifter drives SDA bits and reports byte completion); SDA/SCL control lines feed the open-drain pad logic.

Parameters:
MAX_DATA_BYTES, 4, maximum data bytes per transfer (1..16)
TIMER_WIDTH, 16, width of the internal delay timer
START_STOP_DELAY, 350, clocks SDA is held low before SCL falls (START), and before SDA rises (STOP)
SCL_RELEASE_DELAY, 157, timer value in STOP at which SCL is released; must be < START_STOP_DELAY
SDA_RELEASE_DELAY, 540, timer value in WAIT_ACK after which SDA is released; must be < ACK_DELAY
ACK_DELAY, 1600, timer value in WAIT_ACK at which ack is sampled
BUS_FREE_DELAY, 300, clocks of idle bus after STOP before done
ABORT_ON_NACK, 1, 1: NACK jumps to STOP; 0: NACK is flagged and the sequence continues

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
start_transfer  in  1  request; accepted only in IDLE
slave_address  in  7  7-bit target address, latched on accept
reg_address  in  16  register address, MSB byte sent first, latched on accept
reg_address_bytes  in  2  number of register-address bytes 0..2 (3 treated as 2)
data  in  8*MAX_DATA_BYTES  payload; byte k = data[8k+7:8k], k=0 sent first
data_bytes  in  clog2(MAX_DATA_BYTES+1)  payload byte count (0 treated as 1, >MAX clamped to MAX)
byte_done  in  1  shifter: current byte fully shifted
ack  in  1  sampled SDA ack level from the shifter, 1 = ACK received
tx_byte  out  8  byte for the shifter
byte_send  out  1  level request to the shifter, held until byte_done
timebase_enable  out  1  enables the SCL timebase
i2c_sda_control  out  1  0 = drive SDA low, 1 = release
i2c_scl_control  out  1  0 = drive SCL low, 1 = release
busy  out  1  high from accept until done
transfer_done  out  1  one-cycle pulse at the end of every transfer
nack_error  out  1  sticky: at least one NACK in the last transfer
nack_index  out  5  byte index (0 = address byte) of the first NACK

Behaviour:
- Reset (asynchronous, any time, including mid-transfer): state IDLE; i2c_sda_control=1, i2c_scl_control=1; tx_byte=0; byte_send=0, timebase_enable=0, busy=0, transfer_done=0, nack_error=0, nack_index=0; timer=0. No STOP is generated on reset.
- Byte list: total N = 1 + R + D. Byte 0 = {slave_address,1'b0}. Then R register bytes, MSB first: for R=2, reg_address[15:8] then [7:0]; for R=1, [7:0] only. Then D data bytes. A byte counter indexes the list.
- Timer: counts +1 per clock while enabled; cleared on every state entry. No wrap occurs within legal parameter ranges.
- IDLE: on start_transfer=1, latch all inputs, compute R and D, and clear nack_error/nack_index. The next cycle has state=START, busy=1, and i2c_sda_control=0.
- START: when timer==START_STOP_DELAY, set i2c_scl_control=0 and timebase_enable=1; enter SEND with counter=0.
- SEND: tx_byte=list[counter] and byte_send=1. i2c_sda_control stays 0 (the shifter owns the bit data). On byte_done, byte_send=0 and enter WAIT_ACK. byte_done is ignored in all other states.
- WAIT_ACK: once timer>SDA_RELEASE_DELAY, i2c_sda_control=1. At timer==ACK_DELAY, sample ack:
  - ACK and counter<N-1: counter+1, i2c_sda_control=0, enter SEND.
  - ACK and last byte: enter STOP.
  - NACK: set nack_error (first NACK also records nack_index=counter). If ABORT_ON_NACK=1, enter STOP; otherwise continue as for ACK.
- STOP: i2c_sda_control=0. At timer==SCL_RELEASE_DELAY, i2c_scl_control=1. At timer==START_STOP_DELAY, i2c_sda_control=1 and timebase_enable=0; enter BUS_FREE.
- BUS_FREE: at timer==BUS_FREE_DELAY, transfer_done=1 for exactly one cycle, busy=0, enter IDLE. A start_transfer in that same cycle is ignored; the earliest accept is the following cycle.
- start_transfer while busy=1 is ignored (not queued). Input changes after accept have no effect.

Test Plan:
- Slave 0x50, reg 0x1234, R=2, D=2, data=0xCDAB, all ACK -> tx_byte sequence A0,12,34,AB,CD; exactly 5 byte_send assertions; transfer_done pulses once; nack_error=0.
- R=0, D=0, slave 0x3C -> sequence 78,00 (D clamped to 1, data byte 0x00); SDA low exactly START_STOP_DELAY cycles before SCL falls.
- NACK on byte 2, ABORT_ON_NACK=1 -> no 4th byte_send; STOP follows; SCL rises at STOP+157 and SDA at STOP+350; nack_error=1, nack_index=2.
- Same NACK with ABORT_ON_NACK=0 -> all N bytes sent; nack_error=1, nack_index=2.
- Reset asserted during SEND of byte 1 -> SDA/SCL=1 and all outputs 0 immediately, without waiting for a clock edge; a new start is then accepted normally.
- start_transfer pulsed while busy, and again on the transfer_done cycle -> both ignored; a start one cycle later is accepted.

Source files
------------

// File: rtl/i2c_write_sequencer_if.sv
// Bundle of the command-side and shifter/pad-side signals of the I2C write sequencer.
// The sequencer connects through the master modport; the surrounding logic uses slave.
interface i2c_write_sequencer_if #(
    parameter int MAX_DATA_BYTES = 4
);
    localparam int DBW = $clog2(MAX_DATA_BYTES + 1);

    logic                        start_transfer;
    logic [6:0]                  slave_address;
    logic [15:0]                 reg_address;
    logic [1:0]                  reg_address_bytes;
    logic [8*MAX_DATA_BYTES-1:0] data;
    logic [DBW-1:0]              data_bytes;
    logic                        byte_done;
    logic                        ack;
    logic [7:0]                  tx_byte;
    logic                        byte_send;
    logic                        timebase_enable;
    logic                        i2c_sda_control;
    logic                        i2c_scl_control;
    logic                        busy;
    logic                        transfer_done;
    logic                        nack_error;
    logic [4:0]                  nack_index;

    modport master (
        input  start_transfer, slave_address, reg_address, reg_address_bytes,
               data, data_bytes, byte_done, ack,
        output tx_byte, byte_send, timebase_enable, i2c_sda_control,
               i2c_scl_control, busy, transfer_done, nack_error, nack_index
    );

    modport slave (
        output start_transfer, slave_address, reg_address, reg_address_bytes,
               data, data_bytes, byte_done, ack,
        input  tx_byte, byte_send, timebase_enable, i2c_sda_control,
               i2c_scl_control, busy, transfer_done, nack_error, nack_index
    );
endinterface

// File: rtl/i2c_write_sequencer.sv
// Sequences a full I2C write (START, address, 0-2 register bytes, data bytes, STOP,
// bus-free) around an external byte shifter, with NACK capture and optional abort.
module i2c_write_sequencer #(
    parameter int MAX_DATA_BYTES    = 4,
    parameter int TIMER_WIDTH       = 16,
    parameter int START_STOP_DELAY  = 350,
    parameter int SCL_RELEASE_DELAY = 157,
    parameter int SDA_RELEASE_DELAY = 540,
    parameter int ACK_DELAY         = 1600,
    parameter int BUS_FREE_DELAY    = 300,
    parameter bit ABORT_ON_NACK     = 1'b1
) (
    input  logic                  clock,
    input  logic                  reset,
    i2c_write_sequencer_if.master bus
);
    localparam int DBW = $clog2(MAX_DATA_BYTES + 1);
    localparam int DW  = 8 * MAX_DATA_BYTES;
    localparam logic [TIMER_WIDTH-1:0] T_SS  = TIMER_WIDTH'(START_STOP_DELAY);
    localparam logic [TIMER_WIDTH-1:0] T_SCL = TIMER_WIDTH'(SCL_RELEASE_DELAY);
    localparam logic [TIMER_WIDTH-1:0] T_SDA = TIMER_WIDTH'(SDA_RELEASE_DELAY);
    localparam logic [TIMER_WIDTH-1:0] T_ACK = TIMER_WIDTH'(ACK_DELAY);
    localparam logic [TIMER_WIDTH-1:0] T_BF  = TIMER_WIDTH'(BUS_FREE_DELAY);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_SEND, S_WAIT_ACK, S_STOP, S_BUS_FREE
    } state_t;

    state_t                 state_q, state_d;
    logic [TIMER_WIDTH-1:0] timer_q, timer_d, tmr_nxt_s;
    logic [4:0]             cnt_q, cnt_d, last_q, last_d;
    logic [6:0]             addr_q, addr_d;
    logic [15:0]            reg_q, reg_d;
    logic [1:0]             reg_bytes_q, reg_bytes_d;
    logic [DW-1:0]          data_q, data_d;
    logic [7:0]             tx_byte_q, tx_byte_d;
    logic                   byte_send_q, byte_send_d;
    logic                   tbe_q, tbe_d;
    logic                   sda_q, sda_d;
    logic                   scl_q, scl_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   nack_error_q, nack_error_d;
    logic [4:0]             nack_index_q, nack_index_d;
    logic [1:0]             r_s;
    logic [DBW-1:0]         d_s;
    logic                   load_tx_s;
    logic [4:0]             data_idx_s;
    logic [7:0]             list_byte_s;

    // Delays act on the timer value of the cycle in which the output changes,
    // so each event lands exactly its delay after state entry.
    assign tmr_nxt_s = timer_q + TIMER_WIDTH'(1);

    // Clamp the requested register-byte and data-byte counts.
    always_comb begin
        r_s = (bus.reg_address_bytes == 2'd3) ? 2'd2 : bus.reg_address_bytes;
        if (bus.data_bytes == DBW'(0)) begin
            d_s = DBW'(1);
        end else if (bus.data_bytes > DBW'(MAX_DATA_BYTES)) begin
            d_s = DBW'(MAX_DATA_BYTES);
        end else begin
            d_s = bus.data_bytes;
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_d       = last_q;
        addr_d       = addr_q;
        reg_d        = reg_q;
        reg_bytes_d  = reg_bytes_q;
        data_d       = data_q;
        byte_send_d  = byte_send_q;
        tbe_d        = tbe_q;
        sda_d        = sda_q;
        scl_d        = scl_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        nack_error_d = nack_error_q;
        nack_index_d = nack_index_q;
        load_tx_s    = 1'b0;
        case (state_q)
            S_IDLE: begin
                // done_q high marks the completion cycle, where a new request is refused
                if (bus.start_transfer && !done_q) begin
                    addr_d       = bus.slave_address;
                    reg_d        = bus.reg_address;
                    reg_bytes_d  = r_s;
                    data_d       = bus.data;
                    last_d       = {3'b000, r_s} + 5'(d_s);
                    nack_error_d = 1'b0;
                    nack_index_d = 5'd0;
                    busy_d       = 1'b1;
                    sda_d        = 1'b0;
                    state_d      = S_START;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_START: begin
                if (tmr_nxt_s == T_SS) begin
                    scl_d       = 1'b0;
                    tbe_d       = 1'b1;
                    cnt_d       = 5'd0;
                    load_tx_s   = 1'b1;
                    byte_send_d = 1'b1;
                    state_d     = S_SEND;
                end else begin
                    state_d = S_START;
                end
            end
            S_SEND: begin
                if (bus.byte_done) begin
                    byte_send_d = 1'b0;
                    state_d     = S_WAIT_ACK;
                end else begin
                    state_d = S_SEND;
                end
            end
            S_WAIT_ACK: begin
                if (tmr_nxt_s > T_SDA) begin
                    sda_d = 1'b1;
                end else begin
                    sda_d = sda_q;
                end
                if (tmr_nxt_s == T_ACK) begin
                    if (!bus.ack) begin
                        nack_error_d = 1'b1;
                        nack_index_d = nack_error_q ? nack_index_q : cnt_q;
                    end else begin
                        nack_error_d = nack_error_q;
                    end
                    sda_d = 1'b0;
                    if (!bus.ack && ABORT_ON_NACK) begin
                        state_d = S_STOP;
                    end else if (cnt_q < last_q) begin
                        cnt_d       = cnt_q + 5'd1;
                        load_tx_s   = 1'b1;
                        byte_send_d = 1'b1;
                        state_d     = S_SEND;
                    end else begin
                        state_d = S_STOP;
                    end
                end else begin
                    state_d = S_WAIT_ACK;
                end
            end
            S_STOP: begin
                if (tmr_nxt_s == T_SCL) begin
                    scl_d = 1'b1;
                end else begin
                    scl_d = scl_q;
                end
                if (tmr_nxt_s == T_SS) begin
                    sda_d   = 1'b1;
                    tbe_d   = 1'b0;
                    state_d = S_BUS_FREE;
                end else begin
                    state_d = S_STOP;
                end
            end
            S_BUS_FREE: begin
                if (tmr_nxt_s == T_BF) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    state_d = S_BUS_FREE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Timer restarts on every state change and only runs in the timed states.
    always_comb begin
        if (state_d != state_q) begin
            timer_d = '0;
        end else if (state_q == S_IDLE || state_q == S_SEND) begin
            timer_d = timer_q;
        end else begin
            timer_d = tmr_nxt_s;
        end
    end

    // Select the byte-list entry for the counter value that SEND is about to use.
    always_comb begin
        data_idx_s = cnt_d - 5'd1 - {3'b000, reg_bytes_q};
        if (cnt_d == 5'd0) begin
            list_byte_s = {addr_q, 1'b0};
        end else if ({3'b000, reg_bytes_q} >= cnt_d) begin
            list_byte_s = (reg_bytes_q == 2'd2 && cnt_d == 5'd1) ? reg_q[15:8] : reg_q[7:0];
        end else begin
            list_byte_s = data_q[{data_idx_s, 3'b000} +: 8];
        end
        tx_byte_d = load_tx_s ? list_byte_s : tx_byte_q;
    end

    // State and output registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            timer_q      <= '0;
            cnt_q        <= 5'd0;
            last_q       <= 5'd0;
            addr_q       <= 7'd0;
            reg_q        <= 16'd0;
            reg_bytes_q  <= 2'd0;
            data_q       <= '0;
            tx_byte_q    <= 8'd0;
            byte_send_q  <= 1'b0;
            tbe_q        <= 1'b0;
            sda_q        <= 1'b1;
            scl_q        <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            nack_error_q <= 1'b0;
            nack_index_q <= 5'd0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            cnt_q        <= cnt_d;
            last_q       <= last_d;
            addr_q       <= addr_d;
            reg_q        <= reg_d;
            reg_bytes_q  <= reg_bytes_d;
            data_q       <= data_d;
            tx_byte_q    <= tx_byte_d;
            byte_send_q  <= byte_send_d;
            tbe_q        <= tbe_d;
            sda_q        <= sda_d;
            scl_q        <= scl_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            nack_error_q <= nack_error_d;
            nack_index_q <= nack_index_d;
        end
    end

    assign bus.tx_byte         = tx_byte_q;
    assign bus.byte_send       = byte_send_q;
    assign bus.timebase_enable = tbe_q;
    assign bus.i2c_sda_control = sda_q;
    assign bus.i2c_scl_control = scl_q;
    assign bus.busy            = busy_q;
    assign bus.transfer_done   = done_q;
    assign bus.nack_error      = nack_error_q;
    assign bus.nack_index      = nack_index_q;
endmodule

// File: tb/tb_i2c_write_sequencer.sv
// Scoreboard bench: expected bytes and completion status are queued per transfer,
// monitors pop them on each byte_send rise and on transfer_done.
module tb_i2c_write_sequencer;
    logic clock;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    int   sent[2];
    int   sends[2];
    int   nack_at[2];
    logic [7:0] q_tx_a[$];
    logic [7:0] q_tx_b[$];
    int   q_dn_a[$];
    int   q_dn_b[$];

    i2c_write_sequencer_if #(.MAX_DATA_BYTES(4)) ifa ();
    i2c_write_sequencer_if #(.MAX_DATA_BYTES(4)) ifb ();

    i2c_write_sequencer #(.ABORT_ON_NACK(1'b1)) dut_a (.clock(clock), .reset(reset), .bus(ifa.master));
    i2c_write_sequencer #(.ABORT_ON_NACK(1'b0)) dut_b (.clock(clock), .reset(reset), .bus(ifb.master));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // Queue n hand-computed bytes (byte k in v[8k+:8]) and the completion word {nack_error,nack_index}.
    task automatic expect_seq(input int inst, input int n, input logic [63:0] v, input int dn, input int nk);
        for (int k = 0; k < n; k++) begin
            if (inst == 0) q_tx_a.push_back(v[8*k +: 8]);
            else           q_tx_b.push_back(v[8*k +: 8]);
        end
        if (inst == 0) q_dn_a.push_back(dn);
        else           q_dn_b.push_back(dn);
        nack_at[inst] = nk;
        sent[inst]    = 0;
        sends[inst]   = 0;
    endtask

    task automatic start_xfer(input int inst, input logic [6:0] sa, input logic [15:0] ra,
                              input logic [1:0] rb, input logic [31:0] dat, input logic [2:0] db);
        @(negedge clock);
        if (inst == 0) begin
            ifa.slave_address = sa; ifa.reg_address = ra; ifa.reg_address_bytes = rb;
            ifa.data = dat; ifa.data_bytes = db; ifa.start_transfer = 1'b1;
        end else begin
            ifb.slave_address = sa; ifb.reg_address = ra; ifb.reg_address_bytes = rb;
            ifb.data = dat; ifb.data_bytes = db; ifb.start_transfer = 1'b1;
        end
        @(negedge clock);
        if (inst == 0) begin
            ifa.start_transfer = 1'b0; ifa.slave_address = 7'h7F; ifa.reg_address = 16'hFFFF;
            ifa.data = 32'hFFFF_FFFF; ifa.reg_address_bytes = 2'd0; ifa.data_bytes = 3'd4;
            check("accept busy", int'(ifa.busy), 1);
            check("accept sda", int'(ifa.i2c_sda_control), 0);
        end else begin
            ifb.start_transfer = 1'b0; ifb.slave_address = 7'h7F; ifb.reg_address = 16'hFFFF;
            ifb.data = 32'hFFFF_FFFF; ifb.reg_address_bytes = 2'd0; ifb.data_bytes = 3'd4;
            check("accept busy b", int'(ifb.busy), 1);
            check("accept sda b", int'(ifb.i2c_sda_control), 0);
        end
    endtask

    task automatic wait_done(input int inst, input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 20000 && !seen; i++) begin
            @(negedge clock);
            seen = (inst == 0) ? ifa.transfer_done : ifb.transfer_done;
        end
        check({name, " done seen"}, int'(seen), 1);
    endtask

    // Byte shifter models: finish each byte 12 cycles after byte_send, ack unless indexed NACK.
    initial begin
        int cnt;
        cnt = 0;
        forever begin
            @(negedge clock);
            if (ifa.byte_send && !ifa.byte_done) begin
                cnt++;
                if (cnt == 12) begin
                    ifa.byte_done = 1'b1;
                    ifa.ack = (sent[0] != nack_at[0]);
                    sent[0]++;
                    cnt = 0;
                end
            end else begin
                ifa.byte_done = 1'b0;
                cnt = 0;
            end
        end
    end

    initial begin
        int cnt;
        cnt = 0;
        forever begin
            @(negedge clock);
            if (ifb.byte_send && !ifb.byte_done) begin
                cnt++;
                if (cnt == 12) begin
                    ifb.byte_done = 1'b1;
                    ifb.ack = (sent[1] != nack_at[1]);
                    sent[1]++;
                    cnt = 0;
                end
            end else begin
                ifb.byte_done = 1'b0;
                cnt = 0;
            end
        end
    end

    // Monitors: pop and compare on byte_send rising and on each transfer_done cycle.
    initial begin
        bit bs_prev, dn_prev;
        bs_prev = 1'b0; dn_prev = 1'b0;
        forever begin
            @(negedge clock);
            if (!reset) begin
                if (ifa.byte_send && !bs_prev) begin
                    sends[0]++;
                    if (q_tx_a.size() == 0) check("tx_byte a unexpected send", int'(ifa.tx_byte), -1);
                    else check("tx_byte a", int'(ifa.tx_byte), int'(q_tx_a.pop_front()));
                end
                if (ifa.transfer_done) begin
                    check("done a single cycle", int'(dn_prev), 0);
                    check("done a busy", int'(ifa.busy), 0);
                    if (q_dn_a.size() == 0) check("done a unexpected", 1, 0);
                    else check("nack status a", int'({ifa.nack_error, ifa.nack_index}), q_dn_a.pop_front());
                end
            end
            bs_prev = ifa.byte_send;
            dn_prev = ifa.transfer_done;
        end
    end

    initial begin
        bit bs_prev, dn_prev;
        bs_prev = 1'b0; dn_prev = 1'b0;
        forever begin
            @(negedge clock);
            if (!reset) begin
                if (ifb.byte_send && !bs_prev) begin
                    sends[1]++;
                    if (q_tx_b.size() == 0) check("tx_byte b unexpected send", int'(ifb.tx_byte), -1);
                    else check("tx_byte b", int'(ifb.tx_byte), int'(q_tx_b.pop_front()));
                end
                if (ifb.transfer_done) begin
                    check("done b single cycle", int'(dn_prev), 0);
                    if (q_dn_b.size() == 0) check("done b unexpected", 1, 0);
                    else check("nack status b", int'({ifb.nack_error, ifb.nack_index}), q_dn_b.pop_front());
                end
            end
            bs_prev = ifb.byte_send;
            dn_prev = ifb.transfer_done;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  k, ksc;
        bit  seen;
        reset = 1'b1;
        nack_at[0] = -1; nack_at[1] = -1;
        sent[0] = 0; sent[1] = 0; sends[0] = 0; sends[1] = 0;
        ifa.start_transfer = 1'b0; ifa.slave_address = 7'h00; ifa.reg_address = 16'h0000;
        ifa.reg_address_bytes = 2'd0; ifa.data = 32'h0; ifa.data_bytes = 3'd0;
        ifa.byte_done = 1'b0; ifa.ack = 1'b1;
        ifb.start_transfer = 1'b0; ifb.slave_address = 7'h00; ifb.reg_address = 16'h0000;
        ifb.reg_address_bytes = 2'd0; ifb.data = 32'h0; ifb.data_bytes = 3'd0;
        ifb.byte_done = 1'b0; ifb.ack = 1'b1;
        repeat (3) @(negedge clock);
        check("reset sda", int'(ifa.i2c_sda_control), 1);
        check("reset scl", int'(ifa.i2c_scl_control), 1);
        check("reset busy", int'(ifa.busy), 0);
        check("reset tx_byte", int'(ifa.tx_byte), 0);
        check("reset tbe", int'(ifa.timebase_enable), 0);
        reset = 1'b0;

        // T1: full list A0,12,34,AB,CD, all ACK
        expect_seq(0, 5, 64'h0000_00CD_AB34_12A0, 0, -1);
        start_xfer(0, 7'h50, 16'h1234, 2'd2, 32'h0000_CDAB, 3'd2);
        wait_done(0, "t1");
        @(negedge clock);
        check("t1 byte_send count", sends[0], 5);

        // T2: R=0, D=0 -> 78,00; SDA low exactly 350 cycles before SCL falls
        expect_seq(0, 2, 64'h0000_0000_0000_0078, 0, -1);
        start_xfer(0, 7'h3C, 16'hBEEF, 2'd0, 32'hFFFF_FF00, 3'd0);
        k = 1;
        for (int i = 0; i < 1000 && ifa.i2c_scl_control; i++) begin
            @(negedge clock);
            if (ifa.i2c_scl_control) k++;
        end
        check("t2 sda-low to scl-fall", k, 350);
        wait_done(0, "t2");
        @(negedge clock);
        check("t2 byte_send count", sends[0], 2);

        // T3: NACK on byte 2 with abort -> STOP, SCL at +157, SDA at +350
        expect_seq(0, 3, 64'h0000_0000_0034_12A0, 32 + 2, 2);
        start_xfer(0, 7'h50, 16'h1234, 2'd2, 32'h0000_CDAB, 3'd2);
        seen = 1'b0;
        for (int i = 0; i < 10000 && !seen; i++) begin @(negedge clock); seen = (sent[0] == 3); end
        seen = 1'b0;
        for (int i = 0; i < 2000 && !seen; i++) begin @(negedge clock); seen = ifa.i2c_sda_control; end
        seen = 1'b0;
        for (int i = 0; i < 2000 && !seen; i++) begin @(negedge clock); seen = !ifa.i2c_sda_control; end
        check("t3 stop entered", int'(seen), 1);
        k = 0; ksc = -1; seen = 1'b0;
        for (int i = 0; i < 1000 && !seen; i++) begin
            @(negedge clock);
            k++;
            if (ifa.i2c_scl_control && ksc < 0) ksc = k;
            seen = ifa.i2c_sda_control;
        end
        check("t3 scl release offset", ksc, 157);
        check("t3 sda release offset", k, 350);
        wait_done(0, "t3");
        @(negedge clock);
        check("t3 byte_send count", sends[0], 3);
        check("t3 sticky nack_error", int'(ifa.nack_error), 1);
        #2 reset = 1'b1;
        #1 check("reset clears nack_error", int'(ifa.nack_error), 0);
        check("reset clears nack_index", int'(ifa.nack_index), 0);
        @(negedge clock);
        reset = 1'b0;

        // T4: no abort, clamps R=3->2 and D=7->4: NACK flagged, all 7 bytes sent
        expect_seq(1, 7, 64'h0044_3322_1134_12A0, 32 + 2, 2);
        start_xfer(1, 7'h50, 16'h1234, 2'd3, 32'h4433_2211, 3'd7);
        wait_done(1, "t4");
        @(negedge clock);
        check("t4 byte_send count", sends[1], 7);

        // T5: asynchronous reset during SEND of byte 1, then a normal transfer
        expect_seq(0, 5, 64'h0000_00CD_AB34_12A0, 0, -1);
        start_xfer(0, 7'h50, 16'h1234, 2'd2, 32'h0000_CDAB, 3'd2);
        seen = 1'b0;
        for (int i = 0; i < 5000 && !seen; i++) begin
            @(negedge clock);
            seen = ifa.byte_send && (ifa.tx_byte == 8'h12);
        end
        check("t5 byte1 in send", int'(seen), 1);
        #2 reset = 1'b1;
        #1;
        check("t5 rst sda", int'(ifa.i2c_sda_control), 1);
        check("t5 rst scl", int'(ifa.i2c_scl_control), 1);
        check("t5 rst tx_byte", int'(ifa.tx_byte), 0);
        check("t5 rst byte_send", int'(ifa.byte_send), 0);
        check("t5 rst tbe", int'(ifa.timebase_enable), 0);
        check("t5 rst busy", int'(ifa.busy), 0);
        check("t5 rst done", int'(ifa.transfer_done), 0);
        check("t5 unsent bytes", q_tx_a.size(), 3);
        q_tx_a.delete();
        q_dn_a.delete();
        @(negedge clock);
        reset = 1'b0;
        expect_seq(0, 2, 64'h0000_0000_0000_0078, 0, -1);
        start_xfer(0, 7'h3C, 16'h0000, 2'd0, 32'h0000_0000, 3'd1);
        wait_done(0, "t5");
        @(negedge clock);
        check("t5 byte_send count", sends[0], 2);

        // T6: R=1 -> 54,C3,5A; starts while busy and on the done cycle are ignored
        expect_seq(0, 3, 64'h0000_0000_005A_C354, 0, -1);
        start_xfer(0, 7'h2A, 16'h00C3, 2'd1, 32'h0000_005A, 3'd1);
        repeat (100) @(negedge clock);
        ifa.slave_address = 7'h11; ifa.start_transfer = 1'b1;
        @(negedge clock);
        ifa.start_transfer = 1'b0;
        check("t6 busy during transfer", int'(ifa.busy), 1);
        wait_done(0, "t6");
        check("t6 byte_send count", sends[0], 3);
        expect_seq(0, 2, 64'h0000_0000_0000_9922, 0, -1);
        ifa.slave_address = 7'h11; ifa.reg_address_bytes = 2'd0;
        ifa.data = 32'h0000_0099; ifa.data_bytes = 3'd1; ifa.start_transfer = 1'b1;
        @(negedge clock);
        check("t6 done-cycle start ignored", int'(ifa.busy), 0);
        check("t6 sda idle", int'(ifa.i2c_sda_control), 1);
        @(negedge clock);
        ifa.start_transfer = 1'b0;
        check("t6 next-cycle start accepted", int'(ifa.busy), 1);
        wait_done(0, "t6b");
        @(negedge clock);
        check("t6b byte_send count", sends[0], 2);

        check("queue a drained", q_tx_a.size() + q_dn_a.size(), 0);
        check("queue b drained", q_tx_b.size() + q_dn_b.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
